// File: rtl/id_pkg.sv
// id_pkg: opcodes, ALU command encodings, field positions and ID/EXE bundle
// shared by the decode stage and its register file.
package id_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int DST_HI = 25;
  localparam int DST_LO = 21;
  localparam int S1_HI  = 20;
  localparam int S1_LO  = 16;
  localparam int S2_HI  = 15;
  localparam int S2_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_NOR  = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLA  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SRL  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b100101;
  localparam logic [5:0] OP_BEZ  = 6'b101000;
  localparam logic [5:0] OP_BNE  = 6'b101001;
  localparam logic [5:0] OP_JMP  = 6'b101010;
  localparam logic [5:0] OP_COS  = 6'b111111;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLL = 4'b1000;
  localparam logic [3:0] EXE_SRA = 4'b1001;
  localparam logic [3:0] EXE_SRL = 4'b1010;
  localparam logic [3:0] EXE_COS = 4'b1111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [3:0]  exe_cmd;
    logic        wb_en;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic hit(
    input logic [4:0] a,
    input logic [4:0] d,
    input logic       en
  );
    return (a != 5'd0) && en && (a == d);
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: 32x32 register file, r0 hardwired to zero,
// two combinational read ports with write-through from WB.
module id_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_ra,
  input  logic [4:0]  i_rb,
  output logic [31:0] o_ra,
  output logic [31:0] o_rb,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);

  logic [31:0] r_mem [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_ra = r_mem[i_ra];
    if (i_ra == 5'd0)
      o_ra = '0;
    else if (i_we && i_ra == i_wa)
      o_ra = i_wd;
  end

  always_comb begin
    o_rb = r_mem[i_rb];
    if (i_rb == 5'd0)
      o_rb = '0;
    else if (i_we && i_rb == i_wa)
      o_rb = i_wd;
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: decode, register read, branch resolve, hazard stall, ID/EXE reg.
// Define ID_FORWARD_EN to stall non-branches only on an EXE load-use.
module id_stage
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction,
  input  logic        freez_cos,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read,
  input  logic [4:0]  exe_dest,
  input  logic        mem_wb_en,
  input  logic [4:0]  mem_dest,
  output logic        br_taken,
  output logic [31:0] br_addr,
  output logic        freez,
  output logic [31:0] pc_out,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [31:0] st_val,
  output logic [4:0]  dest_out,
  output logic [4:0]  src1_out,
  output logic [4:0]  src2_out,
  output logic [3:0]  exe_cmd,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out
);

  logic [5:0]  w_op;
  logic [4:0]  w_dst;
  logic [4:0]  w_s1;
  logic [4:0]  w_s2;
  logic [15:0] w_imm;
  logic [31:0] w_sx;
  logic [31:0] w_ra;
  logic [31:0] w_rb;
  logic        w_r, w_i, w_ld, w_st;
  logic        w_bez, w_bne, w_jmp, w_cos, w_nop;
  logic [3:0]  w_cmd;
  logic        w_br, w_xe, w_me;
  id_ex_t      w_d;
  id_ex_t      r_q;

  assign w_op  = instruction[OPC_HI:OPC_LO];
  assign w_dst = instruction[DST_HI:DST_LO];
  assign w_s1  = instruction[S1_HI:S1_LO];
  assign w_s2  = instruction[S2_HI:S2_LO];
  assign w_imm = instruction[IMM_HI:IMM_LO];
  assign w_sx  = sext16(w_imm);

  always_comb begin
    w_r   = 1'b0;
    w_i   = 1'b0;
    w_ld  = 1'b0;
    w_st  = 1'b0;
    w_bez = 1'b0;
    w_bne = 1'b0;
    w_jmp = 1'b0;
    w_cos = 1'b0;
    w_nop = 1'b0;
    w_cmd = EXE_ADD;
    unique case (w_op)
      OP_ADD:  w_r = 1'b1;
      OP_SUB:  begin w_r = 1'b1; w_cmd = EXE_SUB; end
      OP_AND:  begin w_r = 1'b1; w_cmd = EXE_AND; end
      OP_OR:   begin w_r = 1'b1; w_cmd = EXE_OR;  end
      OP_NOR:  begin w_r = 1'b1; w_cmd = EXE_NOR; end
      OP_XOR:  begin w_r = 1'b1; w_cmd = EXE_XOR; end
      OP_SLA:  begin w_r = 1'b1; w_cmd = EXE_SLL; end
      OP_SLL:  begin w_r = 1'b1; w_cmd = EXE_SLL; end
      OP_SRA:  begin w_r = 1'b1; w_cmd = EXE_SRA; end
      OP_SRL:  begin w_r = 1'b1; w_cmd = EXE_SRL; end
      OP_ADDI: w_i = 1'b1;
      OP_SUBI: begin w_i = 1'b1; w_cmd = EXE_SUB; end
      OP_LD:   begin w_i = 1'b1; w_ld = 1'b1; end
      OP_ST:   begin w_i = 1'b1; w_st = 1'b1; end
      OP_BEZ:  w_bez = 1'b1;
      OP_BNE:  w_bne = 1'b1;
      OP_JMP:  w_jmp = 1'b1;
      OP_COS:  begin w_cos = 1'b1; w_cmd = EXE_COS; end
      default: w_nop = 1'b1;
    endcase
  end

  // Port B serves src2 for R-type, else the dest field (ST data, BNE).
  id_regfile u_rf (
    .clk  (clk),
    .rst  (rst),
    .i_ra (w_s1),
    .i_rb (w_r ? w_s2 : w_dst),
    .o_ra (w_ra),
    .o_rb (w_rb),
    .i_we (wb_en),
    .i_wa (wb_dest),
    .i_wd (wb_value)
  );

  assign w_br = w_bez | w_bne | w_jmp;

`ifdef ID_FORWARD_EN
  assign w_xe = w_br ? exe_wb_en : exe_mem_read;
  assign w_me = w_br & mem_wb_en;
`else
  logic w_unused_mr;
  assign w_unused_mr = exe_mem_read;
  assign w_xe = exe_wb_en;
  assign w_me = mem_wb_en;
`endif

  assign freez =
    (~(w_nop | w_jmp) &
      (hit(w_s1, exe_dest, w_xe) | hit(w_s1, mem_dest, w_me))) |
    (w_r &
      (hit(w_s2, exe_dest, w_xe) | hit(w_s2, mem_dest, w_me))) |
    ((w_st | w_bne) &
      (hit(w_dst, exe_dest, w_xe) | hit(w_dst, mem_dest, w_me)));

  assign br_taken = ~freez &
    ((w_bez & (w_ra == 32'd0)) |
     (w_bne & (w_ra != w_rb)) |
     w_jmp);

  assign br_addr = pc_in + {w_sx[29:0], 2'b00};

  always_comb begin
    w_d           = '0;
    w_d.pc        = pc_in;
    w_d.val1      = w_ra;
    w_d.val2      = w_i ? w_sx : w_rb;
    w_d.st_val    = w_rb;
    w_d.dest      = w_dst;
`ifdef ID_FORWARD_EN
    w_d.src1      = w_s1;
    w_d.src2      = w_s2;
`endif
    w_d.exe_cmd   = w_cmd;
    w_d.wb_en     = w_r | w_cos | (w_i & ~w_st);
    w_d.mem_read  = w_ld;
    w_d.mem_write = w_st;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= '0;
    else if (!freez_cos)
      r_q <= freez ? '0 : w_d;
  end

  assign pc_out        = r_q.pc;
  assign val1          = r_q.val1;
  assign val2          = r_q.val2;
  assign st_val        = r_q.st_val;
  assign dest_out      = r_q.dest;
  assign src1_out      = r_q.src1;
  assign src2_out      = r_q.src2;
  assign exe_cmd       = r_q.exe_cmd;
  assign wb_en_out     = r_q.wb_en;
  assign mem_read_out  = r_q.mem_read;
  assign mem_write_out = r_q.mem_write;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus randomized decode checked
// against an opcode-table reference model of the decode stage.
module tb_id_stage;

  localparam logic [5:0] O_ADD  = 6'h01;
  localparam logic [5:0] O_OR   = 6'h06;
  localparam logic [5:0] O_ADDI = 6'h20;
  localparam logic [5:0] O_SUBI = 6'h21;
  localparam logic [5:0] O_BEZ  = 6'h28;
  localparam logic [5:0] O_BNE  = 6'h29;
  localparam logic [5:0] O_JMP  = 6'h2A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instruction = '0;
  logic        freez_cos = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic [31:0] wb_value = '0;
  logic        exe_wb_en = 1'b0;
  logic        exe_mem_read = 1'b0;
  logic [4:0]  exe_dest = '0;
  logic        mem_wb_en = 1'b0;
  logic [4:0]  mem_dest = '0;
  logic        br_taken, freez;
  logic [31:0] br_addr, pc_out, val1, val2, st_val;
  logic [4:0]  dest_out, src1_out, src2_out;
  logic [3:0]  exe_cmd;
  logic        wb_en_out, mem_read_out, mem_write_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_reg [32];

  typedef struct {
    logic        fz;
    logic        bt;
    logic [31:0] ba;
    logic [31:0] pc, v1, v2, st;
    logic [4:0]  d, s1, s2;
    logic [3:0]  cmd;
    logic        we, mr, mw;
    bit          cv2, cst;
  } exp_t;

  id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction),
    .freez_cos(freez_cos), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .br_taken(br_taken), .br_addr(br_addr), .freez(freez),
    .pc_out(pc_out), .val1(val1), .val2(val2), .st_val(st_val),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .exe_cmd(exe_cmd), .wb_en_out(wb_en_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < 32; k++) m_reg[k] <= '0;
    else if (wb_en && wb_dest != 5'd0) m_reg[wb_dest] <= wb_value;
  end

  function automatic logic [31:0] iins(logic [5:0] op, logic [4:0] d,
                                       logic [4:0] s1, logic [15:0] imm);
    return {op, d, s1, imm};
  endfunction

  function automatic logic [31:0] rins(logic [5:0] op, logic [4:0] d,
                                       logic [4:0] s1, logic [4:0] s2);
    return {op, d, s1, s2, 11'd0};
  endfunction

  function automatic logic [31:0] mrd(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_dest == a) return wb_value;
    return m_reg[a];
  endfunction

  function automatic logic [149:0] act_vec(bit cv2, bit cst);
    return {pc_out, val1, cv2 ? val2 : 32'd0, cst ? st_val : 32'd0,
            dest_out, src1_out, src2_out, exe_cmd,
            wb_en_out, mem_read_out, mem_write_out};
  endfunction

  function automatic logic [149:0] exp_vec(exp_t e);
    return {e.pc, e.v1, e.cv2 ? e.v2 : 32'd0, e.cst ? e.st : 32'd0,
            e.d, e.s1, e.s2, e.cmd, e.we, e.mr, e.mw};
  endfunction

  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
    exp_t e;
    logic [5:0]  op  = ins[31:26];
    logic [4:0]  d   = ins[25:21];
    logic [4:0]  s1  = ins[20:16];
    logic [4:0]  s2  = ins[15:11];
    logic [31:0] sx  = {{16{ins[15]}}, ins[15:0]};
    bit r  = op inside {6'h01, 6'h03, [6'h05:6'h0C]};
    bit im = op inside {6'h20, 6'h21, 6'h24, 6'h25};
    bit br = op inside {6'h28, 6'h29, 6'h2A};
    bit ok = r || im || br || op == 6'h3F;
    logic [4:0] srcs[$];
    if (ok && op != 6'h2A) srcs.push_back(s1);
    if (r) srcs.push_back(s2);
    if (op == 6'h25 || op == 6'h29) srcs.push_back(d);
    e.fz = 1'b0;
    foreach (srcs[k]) begin
      if (srcs[k] != 5'd0) begin
`ifdef ID_FORWARD_EN
        if (br)
          e.fz |= (exe_wb_en && srcs[k] == exe_dest) ||
                  (mem_wb_en && srcs[k] == mem_dest);
        else
          e.fz |= exe_mem_read && srcs[k] == exe_dest;
`else
        e.fz |= (exe_wb_en && srcs[k] == exe_dest) ||
                (mem_wb_en && srcs[k] == mem_dest);
`endif
      end
    end
    case (op)
      6'h28:   e.bt = (mrd(s1) == 32'd0);
      6'h29:   e.bt = (mrd(s1) != mrd(d));
      6'h2A:   e.bt = 1'b1;
      default: e.bt = 1'b0;
    endcase
    e.bt = e.bt && !e.fz;
    e.ba = pc + (sx * 4);
    e.pc = pc; e.v1 = mrd(s1); e.v2 = im ? sx : mrd(s2); e.st = mrd(d);
    e.d = d; e.cv2 = r || im; e.cst = (op == 6'h25);
`ifdef ID_FORWARD_EN
    e.s1 = s1; e.s2 = s2;
`else
    e.s1 = 5'd0; e.s2 = 5'd0;
`endif
    case (op)
      6'h03, 6'h21:                      e.cmd = 4'b0010;
      6'h05:                             e.cmd = 4'b0100;
      6'h06:                             e.cmd = 4'b0101;
      6'h07:                             e.cmd = 4'b0110;
      6'h08:                             e.cmd = 4'b0111;
      6'h09, 6'h0A:                      e.cmd = 4'b1000;
      6'h0B:                             e.cmd = 4'b1001;
      6'h0C:                             e.cmd = 4'b1010;
      6'h3F:                             e.cmd = 4'b1111;
      default:                           e.cmd = 4'b0000;
    endcase
    e.we = r || op == 6'h20 || op == 6'h21 || op == 6'h24 || op == 6'h3F;
    e.mr = (op == 6'h24);
    e.mw = (op == 6'h25);
    if (e.fz) begin
      e.pc = 0; e.v1 = 0; e.v2 = 0; e.st = 0; e.d = 0; e.s1 = 0; e.s2 = 0;
      e.cmd = 0; e.we = 0; e.mr = 0; e.mw = 0; e.cv2 = 1; e.cst = 1;
    end
    return e;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (act_vec(1, 1) !== 150'd0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", act_vec(1, 1));
    end
    @(posedge clk); #1;
    checks++;
    if (act_vec(1, 1) !== 150'd0 || freez !== 1'b0 || br_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_held got %h fz=%b bt=%b want 0", act_vec(1, 1), freez, br_taken);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_addi();
    @(negedge clk); wb_en = 1; wb_dest = 1; wb_value = 32'h3F49;
    @(negedge clk); wb_dest = 5; wb_value = 32'hAAAA;
    @(negedge clk); wb_en = 0; instruction = iins(O_ADDI, 2, 1, 16'd4); pc_in = 40;
    @(posedge clk); #1;
    checks++;
    if (val1 !== 32'h3F49 || val2 !== 32'd4) begin
      errors++;
      $display("FAIL addi_vals got %h/%h want 00003f49/00000004", val1, val2);
    end
    checks++;
    if (exe_cmd !== 4'b0000 || wb_en_out !== 1'b1 || dest_out !== 5'd2 || pc_out !== 32'd40) begin
      errors++;
      $display("FAIL addi_ctl got cmd=%b wb=%b d=%0d pc=%0d want 0000/1/2/40", exe_cmd, wb_en_out, dest_out, pc_out);
    end
    @(negedge clk); wb_en = 1; wb_dest = 7; wb_value = 32'h1234;
    instruction = iins(O_SUBI, 3, 7, 16'hFFFF);
    @(posedge clk); #1;
    checks++;
    if (val1 !== 32'h1234 || val2 !== 32'hFFFFFFFF || exe_cmd !== 4'b0010) begin
      errors++;
      $display("FAIL write_through got %h/%h/%b want 00001234/ffffffff/0010", val1, val2, exe_cmd);
    end
    @(negedge clk); wb_en = 0;
  endtask

  task automatic test_branch();
    @(negedge clk); instruction = iins(O_JMP, 0, 0, 16'hFFFF); pc_in = 28; #1;
    checks++;
    if (br_taken !== 1'b1 || br_addr !== 32'd24) begin
      errors++;
      $display("FAIL jmp_back got bt=%b addr=%0d want 1/24", br_taken, br_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_en_out !== 1'b0 || mem_write_out !== 1'b0 || mem_read_out !== 1'b0) begin
      errors++;
      $display("FAIL jmp_nop got wb=%b mw=%b mr=%b want 0/0/0", wb_en_out, mem_write_out, mem_read_out);
    end
    @(negedge clk); instruction = iins(O_BNE, 2, 1, 16'd3); pc_in = 100; #1;
    checks++;
    if (br_taken !== 1'b1 || br_addr !== 32'd112) begin
      errors++;
      $display("FAIL bne_taken got bt=%b addr=%0d want 1/112", br_taken, br_addr);
    end
    @(negedge clk); instruction = iins(O_BEZ, 0, 1, 16'd3); #1;
    checks++;
    if (br_taken !== 1'b0) begin
      errors++;
      $display("FAIL bez_not_taken got %b want 0", br_taken);
    end
  endtask

  task automatic test_hazard();
    @(negedge clk); instruction = rins(O_OR, 1, 1, 2);
    exe_dest = 2; exe_wb_en = 1; exe_mem_read = 1; #1;
    checks++;
    if (freez !== 1'b1) begin
      errors++;
      $display("FAIL hazard_exe got %b want 1", freez);
    end
    @(posedge clk); #1;
    checks++;
    if (dest_out !== 5'd0 || wb_en_out !== 1'b0 || exe_cmd !== 4'd0) begin
      errors++;
      $display("FAIL bubble got d=%0d wb=%b cmd=%b want 0/0/0000", dest_out, wb_en_out, exe_cmd);
    end
    @(negedge clk); exe_wb_en = 0; exe_mem_read = 0; #1;
    checks++;
    if (freez !== 1'b0) begin
      errors++;
      $display("FAIL no_hazard got %b want 0", freez);
    end
    @(posedge clk); #1;
    checks++;
    if (exe_cmd !== 4'b0101 || dest_out !== 5'd1 || wb_en_out !== 1'b1 || val1 !== 32'h3F49) begin
      errors++;
      $display("FAIL or_loaded got cmd=%b d=%0d wb=%b v1=%h want 0101/1/1/3f49", exe_cmd, dest_out, wb_en_out, val1);
    end
    @(negedge clk); mem_dest = 1; mem_wb_en = 1; #1;
    checks++;
`ifdef ID_FORWARD_EN
    if (freez !== 1'b0) begin
      errors++;
      $display("FAIL hazard_mem got %b want 0", freez);
    end
`else
    if (freez !== 1'b1) begin
      errors++;
      $display("FAIL hazard_mem got %b want 1", freez);
    end
`endif
    @(negedge clk); mem_wb_en = 0; instruction = rins(O_OR, 1, 0, 0);
    exe_dest = 0; exe_wb_en = 1; #1;
    checks++;
    if (freez !== 1'b0) begin
      errors++;
      $display("FAIL hazard_r0 got %b want 0", freez);
    end
    exe_wb_en = 0;
  endtask

  task automatic test_cos_hold();
    @(negedge clk); instruction = iins(O_ADDI, 2, 1, 16'd4); pc_in = 40;
    @(negedge clk); freez_cos = 1;
    instruction = iins(O_BEZ, 0, 3, 16'd8); pc_in = 100; #1;
    checks++;
    if (br_taken !== 1'b1 || br_addr !== 32'd132) begin
      errors++;
      $display("FAIL cos_bez got bt=%b addr=%0d want 1/132", br_taken, br_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (val1 !== 32'h3F49 || val2 !== 32'd4 || dest_out !== 5'd2 ||
          wb_en_out !== 1'b1 || pc_out !== 32'd40) begin
        errors++;
        $display("FAIL cos_hold%0d got v1=%h v2=%h d=%0d pc=%0d want 3f49/4/2/40", c, val1, val2, dest_out, pc_out);
      end
    end
  endtask

  task automatic test_rst_hold();
    @(negedge clk); instruction = rins(O_OR, 1, 1, 2);
    exe_dest = 2; exe_wb_en = 1; exe_mem_read = 1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (act_vec(1, 1) !== 150'd0) begin
      errors++;
      $display("FAIL rst_in_hold got %h want 0", act_vec(1, 1));
    end
    checks++;
    if (freez !== 1'b1 || br_taken !== 1'b0) begin
      errors++;
      $display("FAIL rst_freez got fz=%b bt=%b want 1/0", freez, br_taken);
    end
    @(negedge clk); rst = 1'b0; freez_cos = 0; exe_wb_en = 0; exe_mem_read = 0;
    instruction = iins(O_ADDI, 6, 5, 16'd0); pc_in = 8;
    @(posedge clk); #1;
    checks++;
    if (val1 !== 32'd0 || wb_en_out !== 1'b1 || dest_out !== 5'd6) begin
      errors++;
      $display("FAIL r5_cleared got v1=%h wb=%b d=%0d want 0/1/6", val1, wb_en_out, dest_out);
    end
  endtask

  task automatic test_forward();
    @(negedge clk); instruction = rins(O_ADD, 1, 2, 3);
    exe_dest = 3; exe_wb_en = 1; exe_mem_read = 0; #1;
    checks++;
`ifdef ID_FORWARD_EN
    if (freez !== 1'b0) begin
      errors++;
      $display("FAIL fwd_alu got %b want 0", freez);
    end
`else
    if (freez !== 1'b1) begin
      errors++;
      $display("FAIL fwd_alu got %b want 1", freez);
    end
`endif
    @(negedge clk); exe_mem_read = 1; #1;
    checks++;
    if (freez !== 1'b1) begin
      errors++;
      $display("FAIL fwd_load got %b want 1", freez);
    end
    @(negedge clk); exe_wb_en = 0; exe_mem_read = 0;
  endtask

  task automatic test_random();
    logic [5:0] ops [22] = '{6'h00, 6'h01, 6'h03, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h20, 6'h21, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2A, 6'h3F, 6'h02, 6'h10, 6'h3E};
    exp_t e;
    exp_t q;
    logic [31:0] rnd;
    logic [4:0]  s2;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rnd = $urandom;
      s2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      instruction = {ops[$urandom_range(0, 21)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), s2, rnd[10:0]};
      pc_in = {$urandom, 2'b00} >> 2 << 2;
      wb_en = ($urandom_range(0, 1) == 1);
      wb_dest = 5'($urandom_range(0, 7));
      wb_value = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      exe_wb_en = ($urandom_range(0, 3) == 0);
      exe_mem_read = ($urandom_range(0, 1) == 1);
      exe_dest = 5'($urandom_range(0, 7));
      mem_wb_en = ($urandom_range(0, 3) == 0);
      mem_dest = 5'($urandom_range(0, 7));
      freez_cos = (n != 0) && ($urandom_range(0, 7) == 0);
      #1;
      e = model(instruction, pc_in);
      checks++;
      if ({freez, br_taken, br_addr} !== {e.fz, e.bt, e.ba}) begin
        errors++;
        $display("FAIL rand_comb%0d ins=%h got fz=%b bt=%b ba=%h want %b/%b/%h",
                 n, instruction, freez, br_taken, br_addr, e.fz, e.bt, e.ba);
      end
      if (!freez_cos) q = e;
      @(posedge clk); #1;
      checks++;
      if (act_vec(q.cv2, q.cst) !== exp_vec(q)) begin
        errors++;
        $display("FAIL rand_idex%0d got %h want %h", n, act_vec(q.cv2, q.cst), exp_vec(q));
      end
    end
    @(negedge clk);
    wb_en = 0; exe_wb_en = 0; mem_wb_en = 0; freez_cos = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_hazard();
    test_cos_hold();
    test_rst_hold();
    test_forward();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
